melody_prog_tx: RTL and testbench
=================================

# melody_prog_tx

Host-side serial programmer for the programmable melody generator. It accepts melody program words over a valid/ready handshake and shifts them out MSB-first on the generator's two-wire programming interface (`pgm_strobe`, `pgm_data`). On request, once all accepted words have been sent, it issues a `reload` pulse so the generator adopts the new program. It sits between the host logic or pin driver and the generator's programming inputs.

## Interface
- `WORD_W`, default 8: bits per program word; must be ≥1.
- `HALF_PERIOD`, default 4: clk cycles per strobe phase (low and high); must be ≥1.
- `RELOAD_CYCLES`, default 4: width of the `reload` pulse in clk cycles; must be ≥1.

- `clk`  in  1  single clock; all logic is rising-edge.
- `restart_n`  in  1  asynchronous active-low reset.
- `word_data`  in  WORD_W  program word; sampled on accept.
- `word_valid`  in  1  host has a word.
- `word_ready`  out  1  block can accept; transfer occurs on a clock edge where valid&ready=1.
- `commit`  in  1  request reload after drain; single-cycle pulse, level tolerated.
- `busy`  out  1  shifting, reloading, or commit pending.
- `pgm_strobe`  out  1  programming strobe; generator samples `pgm_data` on its rising edge.
- `pgm_data`  out  1  programming serial data.
- `reload`  out  1  reload request to generator.

## Operation
- States: IDLE, LO, HI, RELOAD.
- IDLE: `pgm_strobe`=0, `pgm_data`=0, `reload`=0.
- `commit_pending` flag: set by `commit`=1 on any edge, cleared on entry to RELOAD. A commit sampled while in RELOAD sets it again, so a second reload follows.
- `word_ready` = (state==IDLE) & !`commit_pending`, combinational.
- `busy` = (state!=IDLE) | `commit_pending`.
- IDLE with pending commit goes to RELOAD. A pending commit takes priority over `word_valid`, because `word_ready` is low.
- IDLE with accept:
  - load shift register with `word_data`;
  - bit counter = WORD_W;
  - go to LO.
- LO: `pgm_data` = shift register MSB, strobe 0, for HALF_PERIOD cycles, then go to HI.
- HI: strobe 1, data held, for HALF_PERIOD cycles. Then decrement the bit counter and shift left.
  - Counter reaches 0: go to IDLE.
  - Otherwise: go to LO with the next bit.
- RELOAD: `reload`=1, strobe 0, data 0, for RELOAD_CYCLES cycles, then go to IDLE.
- Widths:
  - phase counter is clog2(max(HALF_PERIOD, RELOAD_CYCLES)) bits, minimum 1;
  - bit counter is clog2(WORD_W+1) bits;
  - no wrap permitted.
- Reset mid-operation:
  - all outputs go to 0 immediately and asynchronously, except `word_ready`;
  - the partial word is discarded and `commit_pending` is cleared;
  - after release, the next word is transmitted whole, from its MSB.

## Timing
- Reset values: state IDLE; `pgm_strobe`=0, `pgm_data`=0, `reload`=0, `busy`=0. `word_ready`=1 per its equation, but no transfer can occur while reset is asserted.
- Accept edge E0: the cycle after E0 is the first LO cycle, with bit WORD_W-1 on `pgm_data`.
- Each bit takes 2·HALF_PERIOD cycles. `pgm_data` is stable HALF_PERIOD cycles before and HALF_PERIOD cycles after each strobe rise.
- A word occupies 2·HALF_PERIOD·WORD_W cycles from E0 to re-entering IDLE. Exactly WORD_W strobe rises occur per word.
- With `word_valid` held high, consecutive accepts are 2·HALF_PERIOD·WORD_W+1 cycles apart (65 at defaults). There is one IDLE cycle between words, with strobe and data at 0.
- Commit latched during a word: `reload` rises on the cycle after the final HI phase ends. This is one IDLE cycle, then RELOAD, so `reload` starts 2 cycles after the last strobe fall. It stays high exactly RELOAD_CYCLES cycles.
- Commit while IDLE: `commit_pending` is set at edge E. `reload` rises in the cycle after E+1, because IDLE evaluates the pending flag on the next edge.

## Test plan
- Reset, then release, with no stimulus: strobe=0, data=0, reload=0, busy=0, ready=1 for 100 cycles.
- Single word 0xA5, defaults:
  - exactly 8 strobe rises;
  - `pgm_data` sampled at each rise = 1,0,1,0,0,1,0,1;
  - ready low 64 cycles after accept;
  - busy high for the same 64 cycles.
- Back-to-back 0x00 then 0xFF with `word_valid` held:
  - second accept exactly 65 cycles after the first;
  - 16 rises total, sampled bits 8×0 then 8×1.
- `commit` pulsed during bit 3 of word 0x3C:
  - all 8 bits complete;
  - `reload` high exactly 4 cycles, starting 2 cycles after the last strobe fall;
  - a queued `word_valid` is not accepted until after the reload completes.
- `restart_n` low for 1 cycle after 3 strobe rises of word 0xF0:
  - strobe, data and reload are 0 immediately;
  - resending 0xF0 yields 8 rises with bits 1,1,1,1,0,0,0,0.
- `commit` and `word_valid`(0x81) asserted in the same IDLE cycle:
  - the 4-cycle reload pulse occurs first;
  - the word is then accepted and shifted as 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/melody_prog_tx.sv
// melody_prog_tx: shifts program words MSB-first on pgm_strobe/pgm_data, then pulses reload on commit; ports clk, restart_n, word_data/valid/ready, commit, busy, pgm_strobe, pgm_data, reload
module melody_prog_tx #(
  parameter int WORD_W        = 8,
  parameter int HALF_PERIOD   = 4,
  parameter int RELOAD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              restart_n,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              commit,
  output logic              busy,
  output logic              pgm_strobe,
  output logic              pgm_data,
  output logic              reload
);
  localparam int PMAX = HALF_PERIOD > RELOAD_CYCLES ? HALF_PERIOD : RELOAD_CYCLES;
  localparam int PW   = PMAX > 1 ? $clog2(PMAX) : 1;
  localparam int BW   = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, LO, HI, RELOAD} state_t;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              commit_pending_q, commit_pending_d;
  logic              last_half, last_reload;
  always_ff @(posedge clk or negedge restart_n)
    if (!restart_n) begin
      state_q          <= IDLE;
      shift_q          <= '0;
      bit_cnt_q        <= '0;
      phase_q          <= '0;
      commit_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      shift_q          <= shift_d;
      bit_cnt_q        <= bit_cnt_d;
      phase_q          <= phase_d;
      commit_pending_q <= commit_pending_d;
    end
  always_comb begin
    state_d          = state_q;
    shift_d          = shift_q;
    bit_cnt_d        = bit_cnt_q;
    phase_d          = phase_q + PW'(1);
    commit_pending_d = commit_pending_q | commit;
    last_half        = phase_q == PW'(HALF_PERIOD - 1);
    last_reload      = phase_q == PW'(RELOAD_CYCLES - 1);
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (commit_pending_q) begin
          state_d          = RELOAD;
          commit_pending_d = commit;
        end else if (word_valid) begin
          state_d   = LO;
          shift_d   = word_data;
          bit_cnt_d = BW'(WORD_W);
        end
      end
      LO: if (last_half) begin
        state_d = HI;
        phase_d = '0;
      end
      HI: if (last_half) begin
        phase_d   = '0;
        bit_cnt_d = bit_cnt_q - BW'(1);
        shift_d   = shift_q << 1;
        state_d   = bit_cnt_q == BW'(1) ? IDLE : LO;
      end
      default: if (last_reload) begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end
  assign word_ready = (state_q == IDLE) & ~commit_pending_q;
  assign busy       = (state_q != IDLE) | commit_pending_q;
  assign pgm_strobe = state_q == HI;
  assign pgm_data   = ((state_q == LO) | (state_q == HI)) & shift_q[WORD_W-1];
  assign reload     = state_q == RELOAD;
endmodule

// File: tb/tb_melody_prog_tx.sv
// tb_melody_prog_tx: randomized and directed checks of melody_prog_tx against a cycle-count reference model
module tb_melody_prog_tx;
  localparam int W  = 8;
  localparam int HP = 4;
  localparam int RC = 4;
  localparam int WT = 2 * HP * W;
  logic         clk, restart_n, word_valid, word_ready, commit, busy, pgm_strobe, pgm_data, reload;
  logic [W-1:0] word_data;
  int           n_cmp, n_bad, cyc, rem, rel, ready_low, busy_cnt;
  bit           pend, prev_strobe;
  logic [W-1:0] mword;
  int           rise_cyc[$], acc_cyc[$], rel_cyc[$];
  bit           rise_bit[$];
  melody_prog_tx #(.WORD_W(W), .HALF_PERIOD(HP), .RELOAD_CYCLES(RC)) dut (
    .clk(clk), .restart_n(restart_n), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .commit(commit), .busy(busy), .pgm_strobe(pgm_strobe),
    .pgm_data(pgm_data), .reload(reload)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Reference: a word occupies WT cycles, bit k of it occupies 2*HP of them (low half then high half).
  always @(negedge clk) begin
    int  el;
    bit  enter;
    cyc++;
    if (!restart_n) begin
      rem = 0; rel = 0; pend = 0; prev_strobe = 0;
    end else begin
      el = WT - rem;
      chk("cyc_ready",  word_ready, rem == 0 && rel == 0 && !pend);
      chk("cyc_busy",   busy,       rem > 0 || rel > 0 || pend);
      chk("cyc_reload", reload,     rel > 0);
      chk("cyc_strobe", pgm_strobe, rem > 0 && (el % (2 * HP)) >= HP);
      chk("cyc_data",   pgm_data,   rem > 0 && mword[W - 1 - el / (2 * HP)]);
      if (pgm_strobe && !prev_strobe) begin
        rise_cyc.push_back(cyc);
        rise_bit.push_back(pgm_data);
      end
      if (reload) rel_cyc.push_back(cyc);
      if (word_valid && word_ready) acc_cyc.push_back(cyc);
      if (!word_ready) ready_low++;
      if (busy) busy_cnt++;
      enter = rem == 0 && rel == 0 && pend;
      if (rem > 0) rem--;
      else if (rel > 0) rel--;
      else if (pend) rel = RC;
      else if (word_valid) begin
        rem = WT;
        mword = word_data;
      end
      pend = commit || (pend && !enter);
      prev_strobe = pgm_strobe;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_logs();
    rise_cyc.delete(); rise_bit.delete(); acc_cyc.delete(); rel_cyc.delete();
    ready_low = 0; busy_cnt = 0;
  endtask
  task automatic wait_accept();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!word_ready && t < 2000);
    if (!word_ready) chk("accept_timeout", 0, 1);
    tick();
  endtask
  task automatic push_word(input logic [W-1:0] w);
    word_data  = w;
    word_valid = 1'b1;
    wait_accept();
    word_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 5000) begin
      tick();
      t++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    repeat (3) tick();
  endtask
  task automatic wait_rises(input int n);
    int t = 0;
    while (rise_cyc.size() < n && t < 2000) begin
      tick();
      t++;
    end
    if (rise_cyc.size() < n) chk("rise_timeout", rise_cyc.size(), n);
  endtask
  task automatic check_bits(input string tag, input logic [W-1:0] w, input int start);
    logic [W-1:0] v = w;
    for (int i = 0; i < W; i++)
      if (start + i < rise_bit.size()) chk(tag, rise_bit[start + i], v[W - 1 - i]);
  endtask
  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    restart_n = 1'b0; word_valid = 1'b0; commit = 1'b0; word_data = '0;
    repeat (3) tick();
    chk("rst_strobe", pgm_strobe, 0);
    chk("rst_data",   pgm_data,   0);
    chk("rst_reload", reload,     0);
    chk("rst_busy",   busy,       0);
    chk("rst_ready",  word_ready, 1);
    restart_n = 1'b1;
    clear_logs();
    repeat (100) tick();
    chk("idle_rises", rise_cyc.size(), 0);
    chk("idle_busy",  busy_cnt, 0);
    chk("idle_ready_low", ready_low, 0);
    clear_logs();
    push_word(8'hA5);
    wait_idle();
    chk("a5_rises", rise_cyc.size(), W);
    check_bits("a5_bit", 8'hA5, 0);
    chk("a5_ready_low", ready_low, WT);
    chk("a5_busy", busy_cnt, WT);
    clear_logs();
    word_data = 8'h00; word_valid = 1'b1;
    wait_accept();
    word_data = 8'hFF;
    wait_accept();
    word_valid = 1'b0;
    wait_idle();
    chk("b2b_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], WT + 1);
    chk("b2b_rises", rise_cyc.size(), 2 * W);
    check_bits("b2b_bit0", 8'h00, 0);
    check_bits("b2b_bit1", 8'hFF, W);
    clear_logs();
    push_word(8'h3C);
    wait_rises(3);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    word_data = 8'h55; word_valid = 1'b1;
    wait_accept();
    word_valid = 1'b0;
    wait_idle();
    check_bits("cm_bit", 8'h3C, 0);
    chk("cm_reload_len", rel_cyc.size(), RC);
    if (rel_cyc.size() == RC && rise_cyc.size() >= W && acc_cyc.size() == 2) begin
      chk("cm_reload_start", rel_cyc[0] - (rise_cyc[W-1] + HP - 1), 2);
      chk("cm_reload_contig", rel_cyc[RC-1] - rel_cyc[0], RC - 1);
      chk("cm_queued_after", acc_cyc[1] > rel_cyc[RC-1], 1);
    end
    check_bits("cm_next_bit", 8'h55, W);
    clear_logs();
    push_word(8'hF0);
    wait_rises(3);
    restart_n = 1'b0;
    #1;
    chk("ar_strobe", pgm_strobe, 0);
    chk("ar_data",   pgm_data,   0);
    chk("ar_reload", reload,     0);
    chk("ar_busy",   busy,       0);
    tick();
    restart_n = 1'b1;
    clear_logs();
    push_word(8'hF0);
    wait_idle();
    chk("ar_rises", rise_cyc.size(), W);
    check_bits("ar_bit", 8'hF0, 0);
    clear_logs();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    push_word(8'h81);
    wait_idle();
    chk("cv_reload_len", rel_cyc.size(), RC);
    if (rel_cyc.size() == RC && acc_cyc.size() == 1)
      chk("cv_reload_first", acc_cyc[0] > rel_cyc[RC-1], 1);
    chk("cv_rises", rise_cyc.size(), W);
    check_bits("cv_bit", 8'h81, 0);
    for (int i = 0; i < 3000; i++) begin
      tick();
      word_valid = $urandom_range(0, 3) != 0;
      word_data  = W'($urandom);
      commit     = $urandom_range(0, 99) < 3;
      restart_n  = $urandom_range(0, 399) != 0;
    end
    tick();
    restart_n = 1'b1; word_valid = 1'b0; commit = 1'b0;
    tick();
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
